hs_arbiter_seq: RTL

- Clocked sequencer that shares one 4-phase bundled-data output channel (Rreq/REack) between two 4-phase requesters.
- Arbitrates between requesters round-robin and pulses goML for one cycle to capture the winner's data.
- Runs the full 4-phase handshake on both sides.
- Sits between the clocked front-end and the asynchronous REack/goML controller stage; includes handshake timeout detection and a wrapping transaction counter.

---
 rtl/hs_arbiter_seq_if.sv | 32 +++
 rtl/hs_arbiter_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hs_arbiter_seq_if.sv
// Handshake bundle between the two requesters, the shared output channel and the status outputs.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface hs_arbiter_seq_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TXCNT_W = 16
);
  logic               Lreq0;
  logic               Lreq1;
  logic [DATA_W-1:0]  din0;
  logic [DATA_W-1:0]  din1;
  logic               Lack0;
  logic               Lack1;
  logic               Rreq;
  logic               REack;
  logic               goML;
  logic [DATA_W-1:0]  dout;
  logic               sel;
  logic               err;
  logic               err_clr;
  logic               busy;
  logic [TXCNT_W-1:0] tx_cnt;

  modport master (
    output Lreq0, Lreq1, din0, din1, REack, err_clr,
    input  Lack0, Lack1, Rreq, goML, dout, sel, err, busy, tx_cnt
  );

  modport slave (
    input  Lreq0, Lreq1, din0, din1, REack, err_clr,
    output Lack0, Lack1, Rreq, goML, dout, sel, err, busy, tx_cnt
  );
endinterface

// File: rtl/hs_arbiter_seq.sv
// Round-robin sequencer sharing one 4-phase bundled-data channel between two 4-phase requesters.
// Asynchronous inputs are synchronized; every output is driven straight from a flop.
module hs_arbiter_seq #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned TXCNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  hs_arbiter_seq_if.slave bus
);

  localparam int unsigned SyncN      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned TmoClamped = (TIMEOUT < 2) ? 2 : ((TIMEOUT > 255) ? 255 : TIMEOUT);
  localparam logic [7:0]  TmoLast    = 8'(TmoClamped - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StReq,
    StRelease,
    StAck,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic [SyncN-1:0]   lreq0_sync_q, lreq1_sync_q, reack_sync_q;
  logic               s_lreq0, s_lreq1, s_reack;
  logic [7:0]         tmo_q, tmo_d;
  logic               sel_q, sel_d;
  logic               last_q, last_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [TXCNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic               lack0_q, lack1_q, rreq_q, goml_q, err_q, busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lreq0_sync_q <= '0;
      lreq1_sync_q <= '0;
      reack_sync_q <= '0;
    end else begin
      lreq0_sync_q <= {lreq0_sync_q[SyncN-2:0], bus.Lreq0};
      lreq1_sync_q <= {lreq1_sync_q[SyncN-2:0], bus.Lreq1};
      reack_sync_q <= {reack_sync_q[SyncN-2:0], bus.REack};
    end
  end

  assign s_lreq0 = lreq0_sync_q[SyncN-1];
  assign s_lreq1 = lreq1_sync_q[SyncN-1];
  assign s_reack = reack_sync_q[SyncN-1];

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    sel_d    = sel_q;
    last_d   = last_q;
    dout_d   = dout_q;
    tx_cnt_d = tx_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (s_lreq0 || s_lreq1) begin
          sel_d   = (s_lreq0 && s_lreq1) ? ~last_q : s_lreq1;
          // Data is captured on the grant edge so dout is already valid while goML is high.
          dout_d  = sel_d ? bus.din1 : bus.din0;
          state_d = StLatch;
        end
      end
      StLatch: begin
        tmo_d   = '0;
        state_d = StReq;
      end
      StReq: begin
        if (s_reack) begin
          tmo_d   = '0;
          state_d = StRelease;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StRelease: begin
        if (!s_reack) begin
          state_d = StAck;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StAck: begin
        if (!(sel_q ? s_lreq1 : s_lreq0)) begin
          last_d   = sel_q;
          tx_cnt_d = tx_cnt_q + 1'b1;
          state_d  = StIdle;
        end
      end
      StErr: begin
        if (bus.err_clr && !s_reack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      dout_q   <= '0;
      tx_cnt_q <= '0;
      lack0_q  <= 1'b0;
      lack1_q  <= 1'b0;
      rreq_q   <= 1'b0;
      goml_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      dout_q   <= dout_d;
      tx_cnt_q <= tx_cnt_d;
      lack0_q  <= (state_d == StAck) && !sel_d;
      lack1_q  <= (state_d == StAck) && sel_d;
      rreq_q   <= (state_d == StReq);
      goml_q   <= (state_d == StLatch);
      err_q    <= (state_d == StErr);
      busy_q   <= !((state_d == StIdle) || (state_d == StErr));
    end
  end

  assign bus.Lack0  = lack0_q;
  assign bus.Lack1  = lack1_q;
  assign bus.Rreq   = rreq_q;
  assign bus.goML   = goml_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.sel    = sel_q;
  assign bus.dout   = dout_q;
  assign bus.tx_cnt = tx_cnt_q;

`ifndef SYNTHESIS
  a_one_channel: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({bus.Rreq, bus.goML, bus.Lack0, bus.Lack1}));
  a_goml_pulse: assert property (@(posedge clk) disable iff (!rst)
    bus.goML |=> !bus.goML);
`endif

endmodule
